// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl - machine-mode trap sequencer
//
// Sits directly upstream of the MEPC/MSCRATCH register block. At each retiring
// instruction boundary it arbitrates enabled interrupts and synchronous
// exceptions. It produces mcause/mtval and the EPC capture, and redirects
// fetch to the trap vector. It also sequences MRET returns to MEPC. After
// every redirect it holds the front end flushed for a fixed number of cycles.
//
// Parameters
//   FLUSH_CYCLES  cycles flush_out stays high in FLUSH after a redirect (>= 1)
//   MTVEC_ALIGN   low mtvec bits forced to zero for the direct-mode base
//
// Optional feature (compile-time macro TRAP_VECTORED_EN)
//   defined     : mtvec_in[1:0]==2'b01 sends interrupts to base + 4*code.
//                 Exceptions always go to the base.
//   not defined : mtvec mode bits are ignored; every trap goes to the base.
//
// Ports
//   clk_in, rst_in              clock, asynchronous active-low reset
//   instr_valid_in, pc_in       retiring-instruction boundary strobe and PC
//   exc_*_in                    synchronous exception flags (with instr_valid_in)
//   bad_addr_in, instr_in       mtval sources for misaligned / illegal
//   mret_in                     MRET retiring (with instr_valid_in)
//   meip/mtip/msip_in           pending interrupt lines
//   mstatus_mie_in, mie_*_in    global and per-source interrupt enables
//   mtvec_in, epc_in            trap vector CSR, current MEPC (return target)
//   set_epc_out, epc_pc_out     one-cycle MEPC capture strobe and value
//   set_cause_out               one-cycle mcause/mtval write strobe
//   cause_out, mtval_out        mcause / mtval values
//   mie_clr_out                 pulse: MPIE<=MIE, MIE<=0
//   mie_restore_out             pulse: MIE<=MPIE, MPIE<=1
//   redirect_out, redirect_pc_out  fetch redirect pulse and target
//   flush_out                   squash front end / stall retire
//   state_out                   debug view of the FSM (0 RUN,1 TRAP,2 RET,3 FLUSH)
//
// Valid/ready note: there is no back-pressure. instr_valid_in is a one-cycle
// qualifier that is sampled only in RUN. All *_out strobes are single-cycle
// pulses that the consumer must accept in the cycle they are high.
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MTVEC_ALIGN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        instr_valid_in,
  input  logic [31:0] pc_in,
  input  logic        exc_instr_misalign_in,
  input  logic        exc_illegal_in,
  input  logic        exc_ecall_in,
  input  logic        exc_ebreak_in,
  input  logic        exc_load_misalign_in,
  input  logic        exc_store_misalign_in,
  input  logic [31:0] bad_addr_in,
  input  logic [31:0] instr_in,
  input  logic        mret_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  input  logic        mstatus_mie_in,
  input  logic        mie_meie_in,
  input  logic        mie_mtie_in,
  input  logic        mie_msie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] epc_in,
  output logic        set_epc_out,
  output logic [31:0] epc_pc_out,
  output logic        set_cause_out,
  output logic [31:0] cause_out,
  output logic [31:0] mtval_out,
  output logic        mie_clr_out,
  output logic        mie_restore_out,
  output logic        redirect_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_TRAP  = 2'd1,
    ST_RET   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] flush_cnt;

  // ---------------------------------------------------------------------------
  // Interrupt arbitration: MEI > MSI > MTI, gated by the global enable.
  // ---------------------------------------------------------------------------
  logic        irq_mei, irq_msi, irq_mti, irq_pend;
  logic [30:0] irq_code;

  assign irq_mei  = meip_in & mie_meie_in;
  assign irq_msi  = msip_in & mie_msie_in;
  assign irq_mti  = mtip_in & mie_mtie_in;
  assign irq_pend = mstatus_mie_in & (irq_mei | irq_msi | irq_mti);

  always_comb begin
    irq_code = 31'd7;
    if (irq_mei)      irq_code = 31'd11;
    else if (irq_msi) irq_code = 31'd3;
    else              irq_code = 31'd7;
  end

  // ---------------------------------------------------------------------------
  // Exception arbitration. Ebreak ranks first, then instruction misalign,
  // illegal, ecall, load misalign and store misalign.
  // ---------------------------------------------------------------------------
  logic        exc_any;
  logic [30:0] exc_code;
  logic [31:0] exc_tval;

  assign exc_any = exc_ebreak_in | exc_instr_misalign_in | exc_illegal_in |
                   exc_ecall_in | exc_load_misalign_in | exc_store_misalign_in;

  always_comb begin
    exc_code = 31'd0;
    exc_tval = 32'h0;
    if (exc_ebreak_in) begin
      exc_code = 31'd3;
      exc_tval = pc_in;
    end else if (exc_instr_misalign_in) begin
      exc_code = 31'd0;
      exc_tval = bad_addr_in;
    end else if (exc_illegal_in) begin
      exc_code = 31'd2;
      exc_tval = instr_in;
    end else if (exc_ecall_in) begin
      exc_code = 31'd11;
      exc_tval = 32'h0;
    end else if (exc_load_misalign_in) begin
      exc_code = 31'd4;
      exc_tval = bad_addr_in;
    end else if (exc_store_misalign_in) begin
      exc_code = 31'd6;
      exc_tval = bad_addr_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Trap target. The direct base clears the low MTVEC_ALIGN bits.
  // ---------------------------------------------------------------------------
  logic [31:0] base_pc;
  logic [31:0] irq_pc;

  assign base_pc = {mtvec_in[31:MTVEC_ALIGN], {MTVEC_ALIGN{1'b0}}};

`ifdef TRAP_VECTORED_EN
  // Vectored mode applies only to interrupts; the table uses 4-byte slots.
  assign irq_pc = (mtvec_in[1:0] == 2'b01)
                ? ({mtvec_in[31:2], 2'b00} + {irq_code[29:0], 2'b00})
                : base_pc;
`else
  logic unused_vec;
  assign irq_pc     = base_pc;
  assign unused_vec = &{1'b0, mtvec_in, irq_code};
`endif

  // ---------------------------------------------------------------------------
  // Sequencer. The boundary decision loads the cause, EPC and target. It also
  // asserts the strobes directly, so they are high during the TRAP/RET cycle,
  // one cycle after the boundary. Strobes default low, so each one is a
  // single-cycle pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_RUN;
      flush_cnt       <= '0;
      set_epc_out     <= 1'b0;
      set_cause_out   <= 1'b0;
      mie_clr_out     <= 1'b0;
      mie_restore_out <= 1'b0;
      redirect_out    <= 1'b0;
      flush_out       <= 1'b0;
      epc_pc_out      <= 32'h0;
      cause_out       <= 32'h0;
      mtval_out       <= 32'h0;
      redirect_pc_out <= 32'h0;
    end else begin
      set_epc_out     <= 1'b0;
      set_cause_out   <= 1'b0;
      mie_clr_out     <= 1'b0;
      mie_restore_out <= 1'b0;
      redirect_out    <= 1'b0;
      case (state)
        ST_RUN: begin
          if (instr_valid_in) begin
            if (irq_pend || exc_any) begin
              state           <= ST_TRAP;
              flush_cnt       <= CW'(FLUSH_CYCLES);
              flush_out       <= 1'b1;
              set_epc_out     <= 1'b1;
              set_cause_out   <= 1'b1;
              mie_clr_out     <= 1'b1;
              redirect_out    <= 1'b1;
              epc_pc_out      <= pc_in;
              if (irq_pend) begin
                cause_out       <= {1'b1, irq_code};
                mtval_out       <= 32'h0;
                redirect_pc_out <= irq_pc;
              end else begin
                cause_out       <= {1'b0, exc_code};
                mtval_out       <= exc_tval;
                redirect_pc_out <= base_pc;
              end
            end else if (mret_in) begin
              state           <= ST_RET;
              flush_cnt       <= CW'(FLUSH_CYCLES);
              flush_out       <= 1'b1;
              mie_restore_out <= 1'b1;
              redirect_out    <= 1'b1;
              redirect_pc_out <= epc_in;
            end
          end
        end
        ST_TRAP, ST_RET: begin
          state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // The last FLUSH cycle is the one where the counter drops to zero.
          if (flush_cnt <= CW'(1)) begin
            flush_cnt <= '0;
            flush_out <= 1'b0;
            state     <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_out <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule
